trdb_trace_ctrl: RTL and testbench

- Tracing-session controller for the trace encoder.
- Sequences trace enable from the trigger-unit start request, the filter stop request and the user activation bit.
- Asks the packet emitter for START, STOP and periodic RESYNC packets over a valid/ready handshake.
- Its trace_enable_o replaces the bare enable flop as the encoder's enable source.

---
 rtl/trdb_trace_ctrl.sv | 149 ++++++++++++++
 tb/tb_trdb_trace_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trdb_trace_ctrl.sv
// rtl/trdb_trace_ctrl.sv - trace session controller: START/STOP/RESYNC packet requests and encoder enable
// Optional periodic RESYNC requests are built only with TRDB_CTRL_RESYNC_EN defined.
module trdb_trace_ctrl #(
  parameter int unsigned RESYNC_MAX = 256,
  localparam int unsigned CNT_W = $clog2(RESYNC_MAX)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trace_activated_i,
  input  logic       trace_req_on_i,
  input  logic       trace_req_off_i,
  input  logic       inst_valid_i,
  input  logic       pkt_req_ready_i,
  output logic       pkt_req_valid_o,
  output logic [1:0] pkt_req_type_o,
  output logic       trace_enable_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_START   = 2'b01;
  localparam logic [1:0] S_TRACING = 2'b10;
  localparam logic [1:0] S_STOP    = 2'b11;

  localparam logic [1:0] T_START   = 2'b00;
  localparam logic [1:0] T_STOP    = 2'b01;

  logic [1:0] state_q, state_d;
  logic       valid_q, valid_d;
  logic [1:0] type_q, type_d;
  logic       en_q, en_d;
  logic       xfer;
  logic       stop_cond;

  assign xfer      = valid_q && pkt_req_ready_i;
  assign stop_cond = (trace_req_off_i && !trace_req_on_i) || !trace_activated_i;

`ifdef TRDB_CTRL_RESYNC_EN
  localparam logic [1:0] T_RESYNC = 2'b10;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             wrap;

  assign wrap = inst_valid_i && (cnt_q == CNT_W'(RESYNC_MAX - 1));
`else
  logic [CNT_W:0] unused_cfg;
  assign unused_cfg = {inst_valid_i, CNT_W'(RESYNC_MAX - 1)};
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    type_d  = type_q;
    en_d    = en_q;
`ifdef TRDB_CTRL_RESYNC_EN
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (trace_activated_i && trace_req_on_i) begin
          state_d = S_START;
          valid_d = 1'b1;
          type_d  = T_START;
        end
      end
      S_START: begin
        if (xfer) begin
          state_d = S_TRACING;
          valid_d = 1'b0;
          en_d    = 1'b1;
`ifdef TRDB_CTRL_RESYNC_EN
          cnt_d       = '0;
          stop_pend_d = 1'b0;
`endif
        end
      end
      S_TRACING: begin
`ifdef TRDB_CTRL_RESYNC_EN
        if (inst_valid_i) begin
          cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        // An un-transferred RESYNC defers the stop; further wraps merge into it.
        if (valid_q && !xfer) begin
          if (stop_cond) begin
            stop_pend_d = 1'b1;
          end
        end else if (stop_pend_q || stop_cond) begin
          state_d     = S_STOP;
          valid_d     = 1'b1;
          type_d      = T_STOP;
          en_d        = 1'b0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
        end else begin
          valid_d = wrap;
          if (wrap) begin
            type_d = T_RESYNC;
          end
        end
`else
        if (stop_cond) begin
          state_d = S_STOP;
          valid_d = 1'b1;
          type_d  = T_STOP;
          en_d    = 1'b0;
        end
`endif
      end
      default: begin
        en_d = 1'b0;
        if (xfer) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      type_q  <= 2'b00;
      en_q    <= 1'b0;
`ifdef TRDB_CTRL_RESYNC_EN
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      en_q    <= en_d;
`ifdef TRDB_CTRL_RESYNC_EN
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
`endif
    end
  end

  assign pkt_req_valid_o = valid_q;
  assign pkt_req_type_o  = type_q;
  assign trace_enable_o  = en_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// tb/tb_trdb_trace_ctrl.sv - scoreboard bench for trdb_trace_ctrl
module tb_trdb_trace_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       act, on, off, inst, rdy;
  logic       valid;
  logic [1:0] typ;
  logic       en;
  logic [1:0] st;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];

  localparam logic [1:0] P_START  = 2'b00;
  localparam logic [1:0] P_STOP   = 2'b01;
  localparam logic [1:0] P_RESYNC = 2'b10;

  always #5 clk = ~clk;

  trdb_trace_ctrl #(.RESYNC_MAX(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .trace_activated_i (act),
    .trace_req_on_i    (on),
    .trace_req_off_i   (off),
    .inst_valid_i      (inst),
    .pkt_req_ready_i   (rdy),
    .pkt_req_valid_o   (valid),
    .pkt_req_type_o    (typ),
    .trace_enable_o    (en),
    .state_o           (st)
  );

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each negedge with valid && ready precedes exactly one transfer edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pkt: got type %0d expected none at %0t", typ, $time);
      end else begin
        chk("pkt_type", typ, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    act = 1'b0; on = 1'b0; off = 1'b0; inst = 1'b0; rdy = 1'b0;
    #1;
    repeat (2) step();
    chk("rst_state", st, 2'b00);
    chk("rst_valid", {1'b0, valid}, 2'b00);
    chk("rst_type", typ, 2'b00);
    chk("rst_en", {1'b0, en}, 2'b00);
    rst_n = 1'b1;
    step();

    on = 1'b1;
    repeat (2) step();
    on = 1'b0;
    chk("on_no_act_state", st, 2'b00);
    chk("on_no_act_valid", {1'b0, valid}, 2'b00);

    act = 1'b1; on = 1'b1; rdy = 1'b1;
    exp_q.push_back(P_START);
    step();
    on = 1'b0;
    chk("start_state", st, 2'b01);
    chk("start_valid", {1'b0, valid}, 2'b01);
    chk("start_type", typ, P_START);
    chk("start_en", {1'b0, en}, 2'b00);
    step();
    chk("trc_state", st, 2'b10);
    chk("trc_en", {1'b0, en}, 2'b01);
    chk("trc_valid", {1'b0, valid}, 2'b00);

    on = 1'b1; off = 1'b1;
    repeat (3) step();
    chk("on_off_state", st, 2'b10);
    chk("on_off_en", {1'b0, en}, 2'b01);
    on = 1'b0;
    exp_q.push_back(P_STOP);
    step();
    off = 1'b0;
    chk("stop_en", {1'b0, en}, 2'b00);
    chk("stop_state", st, 2'b11);
    chk("stop_valid", {1'b0, valid}, 2'b01);
    step();
    chk("stop_idle_state", st, 2'b00);
    chk("stop_idle_valid", {1'b0, valid}, 2'b00);

    rdy = 1'b0; on = 1'b1;
    step();
    on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {1'b0, valid}, 2'b01);
      chk("hold_type", typ, P_START);
      chk("hold_en", {1'b0, en}, 2'b00);
      step();
    end
    exp_q.push_back(P_START);
    rdy = 1'b1;
    step();
    chk("hold_xfer_state", st, 2'b10);
    chk("hold_xfer_en", {1'b0, en}, 2'b01);

`ifdef TRDB_CTRL_RESYNC_EN
    repeat (3) exp_q.push_back(P_RESYNC);
    inst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("resync_period", {1'b0, valid}, {1'b0, (i % 4) == 0});
    end
    inst = 1'b0;
    step();
    chk("resync_done_valid", {1'b0, valid}, 2'b00);

    rdy = 1'b0; inst = 1'b1;
    repeat (4) step();
    inst = 1'b0;
    chk("rs_out_valid", {1'b0, valid}, 2'b01);
    chk("rs_out_type", typ, P_RESYNC);
    off = 1'b1;
    step();
    off = 1'b0;
    chk("rs_pend_valid", {1'b0, valid}, 2'b01);
    chk("rs_pend_type", typ, P_RESYNC);
    chk("rs_pend_state", st, 2'b10);
    chk("rs_pend_en", {1'b0, en}, 2'b01);
    step();
    chk("rs_pend2_type", typ, P_RESYNC);
    exp_q.push_back(P_RESYNC);
    exp_q.push_back(P_STOP);
    rdy = 1'b1;
    step();
    chk("rs_stop_state", st, 2'b11);
    chk("rs_stop_valid", {1'b0, valid}, 2'b01);
    chk("rs_stop_type", typ, P_STOP);
    chk("rs_stop_en", {1'b0, en}, 2'b00);
    step();
    chk("rs_idle_state", st, 2'b00);
    chk("rs_idle_valid", {1'b0, valid}, 2'b00);
`else
    inst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_resync_valid", {1'b0, valid}, 2'b00);
      chk("no_resync_state", st, 2'b10);
    end
    inst = 1'b0;
    off = 1'b1;
    exp_q.push_back(P_STOP);
    step();
    off = 1'b0;
    chk("nr_stop_state", st, 2'b11);
    chk("nr_stop_type", typ, P_STOP);
    step();
    chk("nr_idle_state", st, 2'b00);
`endif

    on = 1'b1;
    exp_q.push_back(P_START);
    step();
    on = 1'b0;
    step();
    chk("rst2_trc_state", st, 2'b10);
    rdy = 1'b0; off = 1'b1;
    step();
    off = 1'b0;
    chk("rst2_stop_state", st, 2'b11);
    chk("rst2_stop_valid", {1'b0, valid}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", st, 2'b00);
    chk("async_rst_valid", {1'b0, valid}, 2'b00);
    chk("async_rst_en", {1'b0, en}, 2'b00);
    chk("async_rst_type", typ, 2'b00);
    step();
    rst_n = 1'b1;
    step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
